// File: rtl/seg7_hex_capture_if.sv
// seg7_hex_capture_if: frame output bus of the 7-segment capture block.
interface seg7_hex_capture_if #(parameter int NUM_DIGITS = 4);
    logic [4*NUM_DIGITS-1:0] out_value;
    logic [NUM_DIGITS-1:0]   out_invalid;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_overflow;
    modport master(output out_value, out_invalid, out_valid, out_overflow, input out_ready);
    modport slave(input out_value, out_invalid, out_valid, out_overflow, output out_ready);
endinterface

// File: rtl/seg7_hex_capture.sv
// seg7_hex_capture: decodes a multiplexed active-low 7-segment bus back into hex frames.
module seg7_hex_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [NUM_DIGITS-1:0] digit_sel,
    seg7_hex_capture_if.master    cap
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [1:0] F_IDLE = 2'd0, F_COUNT = 2'd1, F_HELD = 2'd2;
    localparam logic [0:0] O_EMPTY = 1'b0, O_FULL = 1'b1;
    localparam logic [6:0] GLYPH [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
        7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001};
    logic [NUM_DIGITS+6:0]   s_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              f_q, f_d;
    logic [0:0]              o_q, o_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d, inv_q, inv_d, out_inv_q;
    logic [4*NUM_DIGITS-1:0] val_q, val_d, out_val_q;
    logic                    ovf_q;
    logic [3:0]              nib;
    logic                    bad, onehot, same, capture, full, load, hs;
    always_comb begin
        nib = '0;
        bad = 1'b1;
        for (int k = 0; k < 16; k++)
            if (~seg_n == GLYPH[k]) begin
                nib = 4'(k);
                bad = 1'b0;
            end
    end
    assign onehot  = (digit_sel != '0) && ((digit_sel & (digit_sel - 1'b1)) == '0);
    assign same    = {digit_sel, seg_n} == s_q;
    // HELD blocks re-capture while the same digit keeps being displayed
    assign capture = onehot && same && f_q != F_HELD && cnt_q == CW'(STABLE_CYCLES - 1);
    assign full    = &mask_q;
    assign hs      = o_q == O_FULL && cap.out_ready;
    assign load    = full && (o_q == O_EMPTY || cap.out_ready);
    always_comb begin
        cnt_d  = (!onehot || !same) ? '0 : (cnt_q == CW'(STABLE_CYCLES) ? cnt_q : cnt_q + CW'(1));
        f_d    = !onehot ? F_IDLE : (capture || (same && f_q == F_HELD)) ? F_HELD : F_COUNT;
        o_d    = load ? O_FULL : hs ? O_EMPTY : o_q;
        mask_d = (full ? '0 : mask_q) | (capture ? digit_sel : '0);
        val_d  = val_q;
        inv_d  = inv_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (capture && digit_sel[i]) begin
                val_d[4*i +: 4] = nib;
                inv_d[i]        = bad;
            end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q       <= '0;
            cnt_q     <= '0;
            f_q       <= F_IDLE;
            o_q       <= O_EMPTY;
            mask_q    <= '0;
            val_q     <= '0;
            inv_q     <= '0;
            out_val_q <= '0;
            out_inv_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            s_q       <= {digit_sel, seg_n};
            cnt_q     <= cnt_d;
            f_q       <= f_d;
            o_q       <= o_d;
            mask_q    <= mask_d;
            val_q     <= val_d;
            inv_q     <= inv_d;
            out_val_q <= load ? val_q : out_val_q;
            out_inv_q <= load ? inv_q : out_inv_q;
            ovf_q     <= ovf_q | (full & ~load);
        end
    end
    assign cap.out_value    = out_val_q;
    assign cap.out_invalid  = out_inv_q;
    assign cap.out_valid    = o_q == O_FULL;
    assign cap.out_overflow = ovf_q;
endmodule
